uart_rx_param: RTL and testbench

Parametrised UART receiver: the next generation of the fixed 8N1, 16x-oversampled receiver. It is configurable in data width, oversampling ratio, parity and stop bits. It takes 3-sample majority votes per bit, reports framing, parity and overrun errors, and delivers frames through a held valid/ready output register. It sits between the pad-side `rx` line and the byte consumer, with `clock_enable` as the baud×OVERSAMPLE tick from the shared baud generator.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_sampler.sv | 48 ++++
 rtl/uart_rx_param.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DELIVER,
    ST_BREAK
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Oversample tick counter with a 3-sample majority vote around the bit centre.
import uart_pkg::*;

module uart_bit_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic CLKIN,
  input  logic RESET,
  input  logic clock_enable,
  input  logic run,
  input  logic rxs,
  output logic bit_done,
  output logic bit_value
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] SAMP_A   = CW'(OVERSAMPLE / 2 - 2);
  localparam logic [CW-1:0] SAMP_B   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SAMP_C   = CW'(OVERSAMPLE / 2);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          samp_a_reg;
  logic          samp_b_reg;

  // cnt_next is the offset of the current tick from the start-bit detection tick
  assign cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      cnt_reg    <= '0;
      samp_a_reg <= 1'b1;
      samp_b_reg <= 1'b1;
    end else if (!run) begin
      cnt_reg <= '0;
    end else if (clock_enable) begin
      cnt_reg <= cnt_next;
      if (cnt_next == SAMP_A) samp_a_reg <= rxs;
      if (cnt_next == SAMP_B) samp_b_reg <= rxs;
    end
  end

  // The third sample is the live line value on the closing tick
  assign bit_done  = run && clock_enable && (cnt_next == SAMP_C);
  assign bit_value = majority3(samp_a_reg, samp_b_reg, rxs);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register and held valid/ready output.
import uart_pkg::*;

module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLKIN,
  input  logic                 RESET,
  input  logic                 clock_enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD_FLIP  = (PARITY == PARITY_ODD);

  logic                 rx_meta_reg;
  logic                 rxs_reg;
  uart_state_t          state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IW-1:0]        bit_idx_reg;
  logic                 stop_idx_reg;
  logic                 par_err_reg;
  logic                 frm_err_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 perr_out_reg;
  logic                 ferr_out_reg;
  logic                 overrun_reg;
  logic                 run;
  logic                 bit_done;
  logic                 bit_value;

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rxs_reg     <= rx_meta_reg;
    end
  end

  assign run = (state_reg == ST_START) || (state_reg == ST_DATA) ||
               (state_reg == ST_PARITY) || (state_reg == ST_STOP);

  uart_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .CLKIN       (CLKIN),
    .RESET       (RESET),
    .clock_enable(clock_enable),
    .run         (run),
    .rxs         (rxs_reg),
    .bit_done    (bit_done),
    .bit_value   (bit_value)
  );

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      par_err_reg  <= 1'b0;
      frm_err_reg  <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (valid_reg && ready) valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (clock_enable && !rxs_reg) begin
            par_err_reg  <= 1'b0;
            frm_err_reg  <= 1'b0;
            stop_idx_reg <= 1'b0;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          // The sampler counter already runs from the detection tick, so later
          // bits land on the same centre offset without further adjustment.
          if (bit_done) begin
            if (bit_value) begin
              state_reg <= ST_IDLE;
            end else begin
              bit_idx_reg <= '0;
              state_reg   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shift_reg <= {bit_value, shift_reg[DATA_BITS-1:1]};
            if (bit_idx_reg == LAST_IDX) begin
              state_reg <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            par_err_reg <= (^shift_reg) ^ bit_value ^ ODD_FLIP;
            state_reg   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave right after the last centre sample to tolerate baud mismatch
          if (bit_done) begin
            if (!bit_value) frm_err_reg <= 1'b1;
            if (stop_idx_reg == LAST_STOP) begin
              state_reg <= ST_DELIVER;
            end else begin
              stop_idx_reg <= 1'b1;
            end
          end
        end
        ST_DELIVER: begin
          if (!valid_reg || ready) begin
            data_reg     <= shift_reg;
            perr_out_reg <= par_err_reg;
            ferr_out_reg <= frm_err_reg;
            valid_reg    <= 1'b1;
          end else begin
            overrun_reg <= 1'b1;
          end
          state_reg <= (frm_err_reg && (shift_reg == '0)) ? ST_BREAK : ST_IDLE;
        end
        ST_BREAK: begin
          if (clock_enable && rxs_reg) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign data          = data_reg;
  assign valid         = valid_reg;
  assign parity_error  = perr_out_reg;
  assign framing_error = ferr_out_reg;
  assign overrun       = overrun_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1, 8E1 and 5N2 (OS=8) instances on one clock.
import uart_pkg::*;

module tb_uart_rx_param;

  typedef struct {
    int         sel;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       CLKIN;
  logic       RESET;
  logic       clock_enable;
  logic [2:0] rx_l;
  logic [2:0] rdy_l;

  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, bz0, bz1, bz2;

  logic [8:0] data_w [3];
  logic [2:0] valid_l, pe_l, fe_l, ov_l, bz_l;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ovr_cnt [3];

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut0 (
    .CLKIN(CLKIN), .RESET(RESET), .clock_enable(clock_enable), .rx(rx_l[0]),
    .data(d0), .valid(v0), .ready(rdy_l[0]), .parity_error(pe0),
    .framing_error(fe0), .overrun(ov0), .busy(bz0));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut1 (
    .CLKIN(CLKIN), .RESET(RESET), .clock_enable(clock_enable), .rx(rx_l[1]),
    .data(d1), .valid(v1), .ready(rdy_l[1]), .parity_error(pe1),
    .framing_error(fe1), .overrun(ov1), .busy(bz1));

  uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(2)) dut2 (
    .CLKIN(CLKIN), .RESET(RESET), .clock_enable(clock_enable), .rx(rx_l[2]),
    .data(d2), .valid(v2), .ready(rdy_l[2]), .parity_error(pe2),
    .framing_error(fe2), .overrun(ov2), .busy(bz2));

  assign data_w[0] = {1'b0, d0};
  assign data_w[1] = {1'b0, d1};
  assign data_w[2] = {4'b0, d2};
  assign valid_l = {v2, v1, v0};
  assign pe_l    = {pe2, pe1, pe0};
  assign fe_l    = {fe2, fe1, fe0};
  assign ov_l    = {ov2, ov1, ov0};
  assign bz_l    = {bz2, bz1, bz0};

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  // Oversample tick on every other clock so the gating is exercised
  initial begin
    clock_enable = 1'b0;
    forever begin
      @(negedge CLKIN);
      clock_enable = ~clock_enable;
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) ovr_cnt[i] = 0;
    forever begin
      @(negedge CLKIN);
      for (int i = 0; i < 3; i++) if (ov_l[i] === 1'b1) ovr_cnt[i]++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int os_of(input int sel);
    return (sel == 2) ? 8 : 16;
  endfunction

  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int dbits, input int pbit,
                                           input logic stop1, input logic stop2, input int nstop);
    logic [15:0] b;
    int p;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < dbits; i++) b[1 + i] = d[i];
    p = 1 + dbits;
    if (pbit >= 0) begin
      b[p] = (pbit != 0);
      p++;
    end
    b[p] = stop1;
    if (nstop == 2) b[p + 1] = stop2;
    return b;
  endfunction

  task automatic set_rx(input int sel, input logic v);
    rx_l[sel] = v;
  endtask

  task automatic send_frame(input int sel, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      set_rx(sel, bits[i]);
      repeat (2 * os_of(sel)) @(negedge CLKIN);
    end
  endtask

  task automatic idle_bits(input int sel, input int n);
    set_rx(sel, 1'b1);
    repeat (n * 2 * os_of(sel)) @(negedge CLKIN);
  endtask

  // Pop the oldest expectation, compare against the held output, then accept it
  task automatic expect_frame(input int sel, input string name);
    int   w;
    exp_t e;
    w = 0;
    while (valid_l[sel] !== 1'b1 && w < 4000) begin
      @(negedge CLKIN);
      w++;
    end
    vectors++;
    if (w >= 4000) begin
      miscompares++;
      $display("FAIL %s valid_timeout: valid=%b after %0d cycles, required 1", name, valid_l[sel], w);
    end
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s scoreboard_empty: no expected frame queued", name);
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if ({data_w[sel], pe_l[sel], fe_l[sel]} !== {e.d, e.pe, e.fe}) begin
        miscompares++;
        $display("FAIL %s frame: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                 name, data_w[sel], pe_l[sel], fe_l[sel], e.d, e.pe, e.fe);
      end
      $display("rx%0d %s: data=%h pe=%b fe=%b", sel, name, data_w[sel], pe_l[sel], fe_l[sel]);
    end
    rdy_l[sel] = 1'b1;
    @(negedge CLKIN);
    rdy_l[sel] = 1'b0;
    vectors++;
    if (valid_l[sel] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s accept: valid=%b after handshake, required 0", name, valid_l[sel]);
    end
  endtask

  task automatic test_reset();
    logic [13:0] got;
    RESET = 1'b1;
    rx_l  = 3'b111;
    rdy_l = 3'b000;
    repeat (3) @(negedge CLKIN);
    for (int i = 0; i < 3; i++) begin
      got = {data_w[i], valid_l[i], pe_l[i], fe_l[i], ov_l[i], bz_l[i]};
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got %h, required 0", i, got);
      end
    end
    RESET = 1'b0;
    repeat (8) @(negedge CLKIN);
    $display("reset: released");
  endtask

  task automatic test_basic();
    logic dropped;
    exp_q.push_back('{sel: 0, d: 9'h0A5, pe: 1'b0, fe: 1'b0});
    send_frame(0, mk_frame(9'h0A5, 8, -1, 1'b1, 1'b1, 1), 10);
    dropped = 1'b0;
    repeat (40) begin
      @(negedge CLKIN);
      if (valid_l[0] !== 1'b1) dropped = 1'b1;
    end
    vectors++;
    if (dropped) begin
      miscompares++;
      $display("FAIL basic_hold: valid dropped while ready low, required held 1");
    end
    expect_frame(0, "basic_a5");
    idle_bits(0, 1);
  endtask

  task automatic test_parity();
    // 0x07 has odd weight, so even parity needs a 1 parity bit
    exp_q.push_back('{sel: 1, d: 9'h007, pe: 1'b1, fe: 1'b0});
    send_frame(1, mk_frame(9'h007, 8, 0, 1'b1, 1'b1, 1), 11);
    idle_bits(1, 1);
    expect_frame(1, "parity_bad");
    exp_q.push_back('{sel: 1, d: 9'h007, pe: 1'b0, fe: 1'b0});
    send_frame(1, mk_frame(9'h007, 8, 1, 1'b1, 1'b1, 1), 11);
    idle_bits(1, 1);
    expect_frame(1, "parity_good");
  endtask

  task automatic test_false_start();
    int ovr0;
    ovr0 = ovr_cnt[0];
    set_rx(0, 1'b0);
    repeat (6) @(negedge CLKIN);
    vectors++;
    if (bz_l[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL false_start_detect: busy=%b, required 1", bz_l[0]);
    end
    repeat (2) @(negedge CLKIN);
    idle_bits(0, 3);
    vectors++;
    if ({bz_l[0], valid_l[0]} !== 2'b00 || ovr_cnt[0] != ovr0) begin
      miscompares++;
      $display("FAIL false_start_idle: busy=%b valid=%b overruns=%0d, required 0 0 %0d",
               bz_l[0], valid_l[0], ovr_cnt[0], ovr0);
    end
    $display("rx0 false_start: busy=%b valid=%b", bz_l[0], valid_l[0]);
  endtask

  task automatic test_framing();
    int ovr0;
    exp_q.push_back('{sel: 0, d: 9'h03C, pe: 1'b0, fe: 1'b1});
    send_frame(0, mk_frame(9'h03C, 8, -1, 1'b0, 1'b1, 1), 10);
    idle_bits(0, 2);
    expect_frame(0, "framing_3c");
    // Break: all-zero data, low stop, line stays low well past a frame
    ovr0 = ovr_cnt[0];
    exp_q.push_back('{sel: 0, d: 9'h000, pe: 1'b0, fe: 1'b1});
    send_frame(0, mk_frame(9'h000, 8, -1, 1'b0, 1'b1, 1), 10);
    repeat (30 * 32) @(negedge CLKIN);
    vectors++;
    if ({bz_l[0], valid_l[0]} !== 2'b11 || ovr_cnt[0] != ovr0) begin
      miscompares++;
      $display("FAIL break_hold: busy=%b valid=%b overruns=%0d, required 1 1 %0d",
               bz_l[0], valid_l[0], ovr_cnt[0], ovr0);
    end
    idle_bits(0, 2);
    vectors++;
    if (bz_l[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL break_exit: busy=%b after line high, required 0", bz_l[0]);
    end
    expect_frame(0, "break");
    // Second stop bit low on the two-stop instance
    exp_q.push_back('{sel: 2, d: 9'h015, pe: 1'b0, fe: 1'b1});
    send_frame(2, mk_frame(9'h015, 5, -1, 1'b1, 1'b0, 2), 8);
    idle_bits(2, 2);
    expect_frame(2, "framing_stop2");
  endtask

  task automatic test_back_to_back();
    int   ovr0;
    int   w;
    exp_t e;
    ovr0 = ovr_cnt[0];
    exp_q.push_back('{sel: 0, d: 9'h011, pe: 1'b0, fe: 1'b0});
    send_frame(0, mk_frame(9'h011, 8, -1, 1'b1, 1'b1, 1), 10);
    send_frame(0, mk_frame(9'h022, 8, -1, 1'b1, 1'b1, 1), 10);
    idle_bits(0, 2);
    e = exp_q.pop_front();
    vectors++;
    if ({valid_l[0], data_w[0]} !== {1'b1, e.d}) begin
      miscompares++;
      $display("FAIL b2b_held: valid=%b data=%h, required 1 %h", valid_l[0], data_w[0], e.d);
    end
    vectors++;
    if (ovr_cnt[0] != ovr0 + 1) begin
      miscompares++;
      $display("FAIL b2b_overrun: pulses=%0d, required %0d", ovr_cnt[0] - ovr0, 1);
    end
    $display("rx0 b2b: data=%h overruns=%0d", data_w[0], ovr_cnt[0] - ovr0);
    exp_q.push_back('{sel: 0, d: 9'h033, pe: 1'b0, fe: 1'b0});
    w = 0;
    fork
      send_frame(0, mk_frame(9'h033, 8, -1, 1'b1, 1'b1, 1), 10);
      begin
        while (dut0.state_reg != ST_DELIVER && w < 1000) begin
          @(negedge CLKIN);
          w++;
        end
        rdy_l[0] = 1'b1;
        @(negedge CLKIN);
        rdy_l[0] = 1'b0;
      end
    join
    vectors++;
    if (w >= 1000) begin
      miscompares++;
      $display("FAIL b2b_deliver_timeout: waited %0d cycles", w);
    end
    expect_frame(0, "b2b_33");
    vectors++;
    if (ovr_cnt[0] != ovr0 + 1) begin
      miscompares++;
      $display("FAIL b2b_no_overrun: pulses=%0d, required %0d", ovr_cnt[0] - ovr0, 1);
    end
    idle_bits(0, 1);
  endtask

  task automatic test_reset_midframe(input int sel, input logic [8:0] d, input int dbits,
                                     input int nstop);
    logic [15:0] bits;
    logic [13:0] got;
    bits = mk_frame(d, dbits, -1, 1'b1, 1'b1, nstop);
    send_frame(sel, bits, 5);
    set_rx(sel, bits[5]);
    repeat (os_of(sel)) @(negedge CLKIN);
    RESET = 1'b1;
    @(negedge CLKIN);
    got = {data_w[sel], valid_l[sel], pe_l[sel], fe_l[sel], ov_l[sel], bz_l[sel]};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset[%0d]: got %h, required 0", sel, got);
    end
    RESET = 1'b0;
    idle_bits(sel, 2);
    exp_q.push_back('{sel: sel, d: d, pe: 1'b0, fe: 1'b0});
    send_frame(sel, bits, 1 + dbits + nstop);
    idle_bits(sel, 1);
    expect_frame(sel, "reset_recover");
  endtask

  initial begin
    RESET = 1'b1;
    rx_l  = 3'b111;
    rdy_l = 3'b000;
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_reset_midframe(0, 9'h05A, 8, 1);
    test_reset_midframe(2, 9'h01A, 5, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
